// File: rtl/cfeb_bit_check_pkg.sv
// Shared state encodings and constants for the CFEB bit-check sequencer.
package cfeb_bit_check_pkg;

  localparam int unsigned CLR_BX_DEF = 4;
  localparam int unsigned MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_CLEAR = 2'd1,
    S_ARM   = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  // Four-character ASCII tag of a state for the debug display.
  function automatic logic [31:0] state_ascii(input state_e s);
    logic [31:0] txt;
    case (s)
      S_OFF:   txt = "off ";
      S_CLEAR: txt = "clr ";
      S_ARM:   txt = "arm ";
      S_RUN:   txt = "run ";
      default: txt = "deft";
    endcase
    return txt;
  endfunction

endpackage

// File: rtl/cfeb_bad_bit_count.sv
// Registered population count of the latched bad-bit mask, one cycle of latency.
module cfeb_bad_bit_count
  import cfeb_bit_check_pkg::*;
#(
  parameter int unsigned NBITS = 48,
  parameter int unsigned CNTW  = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-1:0] bits_i,
  output logic [CNTW-1:0]  count_o
);

  logic [CNTW-1:0] count_d;
  logic [CNTW-1:0] count_q;

  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < NBITS; i++) begin
      count_d = count_d + CNTW'(bits_i[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/cfeb_bit_check_ctrl.sv
// Sequencer for the per-bit stuck-high checkers: clear, arm, periodic check_pulse, bad-bit mask.
// Define CFEB_BIT_CHECK_CTRL_DEBUG_EN to add the sm_dsp and check_cnt debug outputs.
module cfeb_bit_check_ctrl
  import cfeb_bit_check_pkg::*;
#(
  parameter int unsigned NBITS  = 48,
  parameter int unsigned PERW   = 16,
  parameter int unsigned CLR_BX = CLR_BX_DEF,
  parameter int unsigned CNTW   = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             check_enable,
  input  logic [PERW-1:0]  check_period,
  input  logic             single_bx_mode_in,
  input  logic             bad_bits_reset,
  input  logic [NBITS-1:0] bit_bad,
  output logic             check_pulse,
  output logic             chk_reset,
  output logic             single_bx_mode,
  output logic [NBITS-1:0] bad_bit_mask,
  output logic             bad_bit_any,
  output logic [CNTW-1:0]  bad_bit_count,
  output logic             ctrl_busy
`ifdef CFEB_BIT_CHECK_CTRL_DEBUG_EN
  ,
  output logic [31:0]      sm_dsp,
  output logic [15:0]      check_cnt
`endif
);

  localparam int unsigned CLRW = (CLR_BX > 1) ? $clog2(CLR_BX) : 1;

  state_e           state_q, state_d;
  logic [CLRW-1:0]  clr_cnt_q, clr_cnt_d;
  logic [PERW-1:0]  per_cnt_q, per_cnt_d;
  logic [PERW-1:0]  reload_val;
  logic             pulse_q, pulse_d;
  logic             chk_reset_q, chk_reset_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic [NBITS-1:0] mask_q, mask_d;
  logic             any_q;

  // Periods below the minimum are stretched to it.
  assign reload_val = (check_period < PERW'(MIN_PERIOD)) ? PERW'(MIN_PERIOD - 1)
                                                         : check_period - PERW'(1);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    per_cnt_d = per_cnt_q;
    pulse_d   = 1'b0;
    mode_d    = mode_q;
    mask_d    = mask_q;

    case (state_q)
      S_OFF: begin
        if (check_enable) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (!check_enable)         state_d = S_OFF;
        else if (bad_bits_reset)   state_d = S_CLEAR;
        else if (clr_cnt_q == '0)  state_d = S_ARM;
        else                       clr_cnt_d = clr_cnt_q - CLRW'(1);
      end
      S_ARM: begin
        per_cnt_d = reload_val;
        if (!check_enable)       state_d = S_OFF;
        else if (bad_bits_reset) state_d = S_CLEAR;
        else                     state_d = S_RUN;
      end
      S_RUN: begin
        mask_d = mask_q | bit_bad;
        if (!check_enable)                     state_d = S_OFF;
        else if (bad_bits_reset)               state_d = S_CLEAR;
        else if (single_bx_mode_in != mode_q)  state_d = S_CLEAR;
        else if (per_cnt_q == '0) begin
          pulse_d   = 1'b1;
          per_cnt_d = reload_val;
        end else begin
          per_cnt_d = per_cnt_q - PERW'(1);
        end
      end
      default: state_d = S_OFF;
    endcase

    // Entering (or restarting) a clear wipes the mask and restarts the hold timer.
    if (state_d == S_CLEAR) begin
      mask_d = '0;
      if (state_q != S_CLEAR || bad_bits_reset) clr_cnt_d = CLRW'(CLR_BX - 1);
    end
    // Mode is captured on entry to arm so the checkers see it during the arm cycle.
    if (state_d == S_ARM && state_q != S_ARM) mode_d = single_bx_mode_in;

    chk_reset_d = (state_d == S_OFF) || (state_d == S_CLEAR);
    busy_d      = (state_d == S_CLEAR) || (state_d == S_ARM);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_OFF;
      clr_cnt_q   <= '0;
      per_cnt_q   <= '0;
      pulse_q     <= 1'b0;
      chk_reset_q <= 1'b1;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      mask_q      <= '0;
      any_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      per_cnt_q   <= per_cnt_d;
      pulse_q     <= pulse_d;
      chk_reset_q <= chk_reset_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      mask_q      <= mask_d;
      any_q       <= |mask_q;
    end
  end

  cfeb_bad_bit_count #(
    .NBITS (NBITS),
    .CNTW  (CNTW)
  ) u_count (
    .clock   (clock),
    .reset   (reset),
    .bits_i  (mask_q),
    .count_o (bad_bit_count)
  );

  assign check_pulse    = pulse_q;
  assign chk_reset      = chk_reset_q;
  assign single_bx_mode = mode_q;
  assign bad_bit_mask   = mask_q;
  assign bad_bit_any    = any_q;
  assign ctrl_busy      = busy_q;

`ifdef CFEB_BIT_CHECK_CTRL_DEBUG_EN
  logic [31:0] sm_dsp_q;
  logic [15:0] check_cnt_q;

  // Saturating pulse count, restarted by every clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      sm_dsp_q    <= state_ascii(S_OFF);
      check_cnt_q <= '0;
    end else begin
      sm_dsp_q <= state_ascii(state_d);
      if (state_d == S_CLEAR)                      check_cnt_q <= '0;
      else if (pulse_d && check_cnt_q != 16'hFFFF) check_cnt_q <= check_cnt_q + 16'd1;
    end
  end

  assign sm_dsp    = sm_dsp_q;
  assign check_cnt = check_cnt_q;
`endif

endmodule

// File: tb/tb_cfeb_bit_check_ctrl.sv
// Self-checking bench for cfeb_bit_check_ctrl; check_pulse timing is scoreboarded.
module tb_cfeb_bit_check_ctrl;

  localparam int unsigned NBITS = 48;
  localparam int unsigned PERW  = 16;
  localparam int unsigned CNTW  = 6;

  logic             clock = 1'b0;
  logic             reset;
  logic             check_enable;
  logic [PERW-1:0]  check_period;
  logic             single_bx_mode_in;
  logic             bad_bits_reset;
  logic [NBITS-1:0] bit_bad;
  logic             check_pulse;
  logic             chk_reset;
  logic             single_bx_mode;
  logic [NBITS-1:0] bad_bit_mask;
  logic             bad_bit_any;
  logic [CNTW-1:0]  bad_bit_count;
  logic             ctrl_busy;
`ifdef CFEB_BIT_CHECK_CTRL_DEBUG_EN
  logic [31:0]      sm_dsp;
  logic [15:0]      check_cnt;
`endif

  int cyc     = 0;
  int n_total = 0;
  int n_bad   = 0;
  int exp_pulse[$];

  cfeb_bit_check_ctrl #(
    .NBITS  (NBITS),
    .PERW   (PERW),
    .CLR_BX (4),
    .CNTW   (CNTW)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .check_enable      (check_enable),
    .check_period      (check_period),
    .single_bx_mode_in (single_bx_mode_in),
    .bad_bits_reset    (bad_bits_reset),
    .bit_bad           (bit_bad),
    .check_pulse       (check_pulse),
    .chk_reset         (chk_reset),
    .single_bx_mode    (single_bx_mode),
    .bad_bit_mask      (bad_bit_mask),
    .bad_bit_any       (bad_bit_any),
    .bad_bit_count     (bad_bit_count),
    .ctrl_busy         (ctrl_busy)
`ifdef CFEB_BIT_CHECK_CTRL_DEBUG_EN
    ,
    .sm_dsp            (sm_dsp),
    .check_cnt         (check_cnt)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pulse"}, 64'(check_pulse),    64'(0));
    chk({tag, "_chkrst"}, 64'(chk_reset),     64'(1));
    chk({tag, "_mode"},  64'(single_bx_mode), 64'(0));
    chk({tag, "_mask"},  64'(bad_bit_mask),   64'(0));
    chk({tag, "_any"},   64'(bad_bit_any),    64'(0));
    chk({tag, "_count"}, 64'(bad_bit_count),  64'(0));
    chk({tag, "_busy"},  64'(ctrl_busy),      64'(0));
  endtask

  // Starts from s_off, expects n pulses at the derived cadence, then disables.
  task automatic run_window(input string tag, input int per, input int n);
    int eff;
    int c0;
    int last;
    eff = (per < 2) ? 2 : per;
    c0 = cyc;
    check_period = PERW'(per);
    check_enable = 1'b1;
    for (int k = 0; k < n; k++) exp_pulse.push_back(c0 + 6 + eff * (k + 1));
    last = c0 + 6 + eff * n;
    wait_until(last);
    check_enable = 1'b0;
    tick(3);
    chk({tag, "_drain"}, 64'(exp_pulse.size()), 64'(0));
  endtask

  // Every observed check_pulse must match the next scheduled cycle.
  always @(negedge clock) begin
    if (check_pulse === 1'b1) begin
      if (exp_pulse.size() == 0) chk("pulse_unexp", 64'(check_pulse), 64'(0));
      else                       chk("pulse_cyc", 64'(cyc), 64'(exp_pulse.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int b;
    int m;
    int r0;
    logic [NBITS-1:0] m547;
    logic [NBITS-1:0] m3;
    logic [NBITS-1:0] m9;
    m547 = (NBITS'(1) << 5) | (NBITS'(1) << 47);
    m3   = NBITS'(1) << 3;
    m9   = NBITS'(1) << 9;

    reset = 1'b1;
    check_enable = 1'b0;
    check_period = '0;
    single_bx_mode_in = 1'b0;
    bad_bits_reset = 1'b0;
    bit_bad = '0;
    tick(3);
    chk_reset_vals("rst");
    reset = 1'b0;
    tick(2);
    chk("off_chkrst", 64'(chk_reset), 64'(1));
    chk("off_busy", 64'(ctrl_busy), 64'(0));

    // Period 10: clear/arm profile and steady cadence.
    c0 = cyc;
    check_period = PERW'(10);
    check_enable = 1'b1;
    exp_pulse.push_back(c0 + 16);
    exp_pulse.push_back(c0 + 26);
    exp_pulse.push_back(c0 + 36);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("p10_chkrst", 64'(chk_reset), 64'(i <= 4));
      chk("p10_busy", 64'(ctrl_busy), 64'(i <= 5));
    end
    wait_until(c0 + 36);
    check_enable = 1'b0;
    tick(3);
    chk("p10_drain", 64'(exp_pulse.size()), 64'(0));

    // Degenerate periods run at the minimum period.
    run_window("p0", 0, 4);
    run_window("p1", 1, 4);
    run_window("p3", 3, 3);

    // Mask capture, then bad_bits_reset on a counter expiry, then mode change.
    c0 = cyc;
    check_period = PERW'(10);
    check_enable = 1'b1;
    exp_pulse.push_back(c0 + 16);
    wait_until(c0 + 8);
    bit_bad = m547;
    tick();
    bit_bad = '0;
    chk("mask_set", 64'(bad_bit_mask), 64'(m547));
    chk("any_lat", 64'(bad_bit_any), 64'(0));
    tick();
    chk("any_set", 64'(bad_bit_any), 64'(1));
    chk("count_set", 64'(bad_bit_count), 64'(2));
    tick(2);
    chk("mask_hold", 64'(bad_bit_mask), 64'(m547));
    chk("any_hold", 64'(bad_bit_any), 64'(1));
    chk("count_hold", 64'(bad_bit_count), 64'(2));

    wait_until(c0 + 25);
    bad_bits_reset = 1'b1;
    tick();
    bad_bits_reset = 1'b0;
    bit_bad = '1;
    chk("bbr_mask", 64'(bad_bit_mask), 64'(0));
    chk("bbr_chkrst", 64'(chk_reset), 64'(1));
    chk("bbr_busy", 64'(ctrl_busy), 64'(1));
    tick();
    chk("bbr_count", 64'(bad_bit_count), 64'(0));
    chk("bbr_any", 64'(bad_bit_any), 64'(0));
    wait_until(c0 + 29);
    chk("bbr_clr4", 64'(chk_reset), 64'(1));
    tick();
    bit_bad = '0;
    chk("bbr_arm_chkrst", 64'(chk_reset), 64'(0));
    chk("bbr_arm_busy", 64'(ctrl_busy), 64'(1));
    chk("bbr_arm_mask", 64'(bad_bit_mask), 64'(0));
    tick();
    chk("bbr_run_mask", 64'(bad_bit_mask), 64'(0));
    chk("bbr_run_count", 64'(bad_bit_count), 64'(0));

    b = c0 + 25;
    exp_pulse.push_back(b + 16);
    m = b + 20;
    wait_until(m);
    single_bx_mode_in = 1'b1;
    tick();
    chk("mode_clr", 64'(chk_reset), 64'(1));
    wait_until(m + 4);
    chk("mode_old", 64'(single_bx_mode), 64'(0));
    tick();
    chk("mode_new", 64'(single_bx_mode), 64'(1));
    chk("mode_arm_chkrst", 64'(chk_reset), 64'(0));
    exp_pulse.push_back(m + 16);
    exp_pulse.push_back(m + 26);
    wait_until(m + 20);
    bit_bad = m3;
    tick();
    bit_bad = '0;

    // Disable and bad_bits_reset together: disable wins, mask retained.
    wait_until(m + 27);
    check_enable = 1'b0;
    bad_bits_reset = 1'b1;
    tick();
    bad_bits_reset = 1'b0;
    chk("off_bbr_chkrst", 64'(chk_reset), 64'(1));
    chk("off_bbr_busy", 64'(ctrl_busy), 64'(0));
    chk("off_bbr_mask", 64'(bad_bit_mask), 64'(m3));
    tick(2);
    chk("off_keep_mask", 64'(bad_bit_mask), 64'(m3));
    chk("off_keep_count", 64'(bad_bit_count), 64'(1));
    chk("off_keep_any", 64'(bad_bit_any), 64'(1));
    chk("mode_drain", 64'(exp_pulse.size()), 64'(0));

    // Synchronous reset in the middle of s_run.
    r0 = cyc;
    check_enable = 1'b1;
    wait_until(r0 + 8);
    bit_bad = m9;
    tick();
    bit_bad = '0;
    wait_until(r0 + 12);
    chk("pre_rst_mode", 64'(single_bx_mode), 64'(1));
    chk("pre_rst_mask", 64'(bad_bit_mask), 64'(m9));
    reset = 1'b1;
    tick();
    chk_reset_vals("midrst");
    reset = 1'b0;
    check_enable = 1'b0;
    single_bx_mode_in = 1'b0;
    tick(20);
    chk("final_drain", 64'(exp_pulse.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
